// File: rtl/run_avg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : run_avg_ctrl
//  Description : Running-average sequencer. Accepts one unsigned sample per
//                valid/ready transfer and keeps the last N = 2**LOG2_N samples
//                in a register ring. It maintains the running sum of the ring
//                and emits one average per accepted sample, together with a
//                single-cycle cnt_tick for the downstream decimal counter.
//                Optional build macro: AVG_ROUND_EN (round-half-up average
//                instead of truncation; latency unchanged).
//
//  Ports       : clk          system clock, rising edge
//                rst          asynchronous reset, active low
//                run          level, 1 = accept samples
//                clr          synchronous clear pulse, aborts and zeroes window
//                in_valid     sample present
//                in_data      sample value [DATA_W-1:0], unsigned
//                in_ready     controller can take a sample this cycle
//                avg_valid    one-cycle strobe, avg_data updated
//                avg_data     latest average [DATA_W-1:0], held between strobes
//                cnt_tick     one-cycle pulse per average, with avg_valid
//                window_full  N samples accepted since last reset/clr
//                busy         controller is not idle
//
//  Revision    : 1.0  initial release
// ============================================================================
module run_avg_ctrl #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              avg_valid,
    output logic [DATA_W-1:0] avg_data,
    output logic              cnt_tick,
    output logic              window_full,
    output logic              busy
);

    localparam int              N        = 2 ** LOG2_N;
    localparam int              SUM_W    = DATA_W + LOG2_N;
    localparam logic [LOG2_N:0] FILL_MAX = (LOG2_N + 1)'(N);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_READ   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [DATA_W-1:0] r_buf [N];
    logic [SUM_W-1:0]  r_sum;
    logic [LOG2_N-1:0] r_wr_ptr;
    logic [LOG2_N:0]   r_fill;
    logic [DATA_W-1:0] r_new;
    logic [DATA_W-1:0] r_old;
    logic [DATA_W-1:0] r_avg;

    logic              w_take;
    logic [SUM_W-1:0]  w_sum_next;
    logic [DATA_W-1:0] w_avg_next;

    // A transfer needs the WAIT state; a simultaneous clr cancels it.
    assign w_take = (r_state == ST_WAIT) && in_valid && !clr;

    // The sum cannot overflow: N samples of at most 2**DATA_W-1 fit SUM_W bits.
    assign w_sum_next = r_sum - SUM_W'(r_old) + SUM_W'(r_new);

`ifdef AVG_ROUND_EN
    logic [SUM_W:0] w_sum_rnd;

    // One extra bit holds sum + N/2; the quotient still fits DATA_W bits.
    assign w_sum_rnd  = {1'b0, w_sum_next} + (SUM_W + 1)'(N / 2);
    assign w_avg_next = DATA_W'(w_sum_rnd >> LOG2_N);
`else
    assign w_avg_next = DATA_W'(w_sum_next >> LOG2_N);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        avg_valid    = 1'b0;
        cnt_tick     = 1'b0;
        busy         = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                in_ready = 1'b1;
                // A transfer takes precedence over run dropping.
                if (in_valid) begin
                    w_state_next = ST_READ;
                end else if (!run) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                w_state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                w_state_next = ST_OUT;
            end
            ST_OUT: begin
                avg_valid    = !clr;
                cnt_tick     = !clr;
                w_state_next = run ? ST_WAIT : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (clr) begin
            w_state_next = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: window ring, running sum, fill level, average register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
            r_sum    <= '0;
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_new    <= '0;
            r_old    <= '0;
            r_avg    <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
            r_sum    <= '0;
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_avg    <= '0;
        end else begin
            if (w_take) begin
                r_new <= in_data;
            end
            if (r_state == ST_READ) begin
                // Slot about to be overwritten; reads 0 until the ring fills.
                r_old <= r_buf[r_wr_ptr];
            end
            if (r_state == ST_UPDATE) begin
                r_sum           <= w_sum_next;
                r_buf[r_wr_ptr] <= r_new;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + 1'b1;
                end
                // Average is taken from the new sum here so that it is
                // already on avg_data during the OUT strobe cycle.
                r_avg <= w_avg_next;
            end
        end
    end

    assign avg_data    = r_avg;
    assign window_full = (r_fill == FILL_MAX);

endmodule
`default_nettype wire

// File: tb/tb_run_avg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_avg_ctrl
//  Description : Self-checking bench for run_avg_ctrl. A reference model of
//                the sample window predicts every average; a separate
//                monitor pops predictions whenever avg_valid is seen.
//                Honours AVG_ROUND_EN the same way as the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_run_avg_ctrl;

    localparam int DATA_W = 8;
    localparam int LOG2_N = 2;
    localparam int N      = 2 ** LOG2_N;

    logic              clk;
    logic              rst;
    logic              run;
    logic              clr;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              avg_valid;
    logic [DATA_W-1:0] avg_data;
    logic              cnt_tick;
    logic              window_full;
    logic              busy;

    run_avg_ctrl #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .avg_valid   (avg_valid),
        .avg_data    (avg_data),
        .cnt_tick    (cnt_tick),
        .window_full (window_full),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int avg;
        bit full;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_avg = 0;
    int   win[N];
    int   wpos  = 0;
    int   nfill = 0;
    bit   after_out = 1'b0;
    bit   run_at_out = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int got, input int exp);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) win[i] = 0;
        wpos  = 0;
        nfill = 0;
        q.delete();
    endfunction

    // ---------------- reference model: sees each handshake at the edge ----
    always @(posedge clk) begin
        int   s;
        exp_t e;
        cyc++;
        if (!rst || clr) begin
            model_clear();
        end else if (in_valid && in_ready) begin
            win[wpos] = int'(in_data);
            wpos      = (wpos + 1) % N;
            if (nfill < N) nfill++;
            s = 0;
            for (int i = 0; i < N; i++) s += win[i];
`ifdef AVG_ROUND_EN
            e.avg = (s + N / 2) / N;
`else
            e.avg = s / N;
`endif
            e.full = (nfill == N);
            e.cyc  = cyc + 2;
            q.push_back(e);
        end
    end

    // ---------------- monitor: compares whenever an average is presented --
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            after_out = 1'b0;
        end else begin
            if (after_out) begin
                check("in_ready_after_out", int'(in_ready), int'(run_at_out));
                check("busy_after_out", int'(busy), int'(run_at_out));
                after_out = 1'b0;
            end
            if (avg_valid) begin
                if (q.size() == 0) begin
                    check("avg_unexpected", int'(avg_valid), 0);
                end else begin
                    e = q.pop_front();
                    check("avg_data", int'(avg_data), e.avg);
                    check("avg_latency", cyc, e.cyc);
                    check("window_full", int'(window_full), int'(e.full));
                    check("cnt_tick", int'(cnt_tick), 1);
                    run_at_out = run;
                    after_out  = 1'b1;
                end
                n_avg++;
            end else if (cnt_tick) begin
                check("cnt_tick_alone", int'(cnt_tick), 0);
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                flag("avg_missing", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    // ---------------- driver helpers ---------------------------------------
    task automatic send(input int d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        for (int k = 0; k < 30 && !done; k++) begin
            @(posedge clk);
            if (in_ready && !clr && rst) done = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        if (!done) flag("send_timeout", 0, 1);
    endtask

    task automatic wait_avgs(input int n);
        int start;
        bit ok;
        start = n_avg;
        ok    = 1'b0;
        for (int k = 0; k < 20 * n && !ok; k++) begin
            @(posedge clk);
            if (n_avg >= start + n) ok = 1'b1;
        end
        #1;
        if (!ok) flag("avg_timeout", n_avg - start, n);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avg_data"}, int'(avg_data), 0);
        check({tag, "_avg_valid"}, int'(avg_valid), 0);
        check({tag, "_cnt_tick"}, int'(cnt_tick), 0);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_window_full"}, int'(window_full), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin
        int start;
        rst      = 1'b0;
        run      = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state, then IDLE -> WAIT one cycle after run
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1; run = 1'b1;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_busy", int'(busy), 0);
        @(negedge clk);
        check("wait_in_ready", int'(in_ready), 1);
        check("wait_busy", int'(busy), 1);

        // Mid-stream asynchronous reset
        send(40);
        wait_avgs(1);
        check("pre_reset_avg", int'(avg_data), 10);
        send(7);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rel_in_ready0", int'(in_ready), 0);
        @(negedge clk);
        check("rel_in_ready1", int'(in_ready), 1);

        // Fill 4, 8, 12, 16 then wrap with 20, 0
        start = n_avg;
        send(4);  wait_avgs(1); check("fill_avg1", int'(avg_data), 1);
        send(8);  wait_avgs(1); check("fill_avg2", int'(avg_data), 3);
        send(12); wait_avgs(1); check("fill_avg3", int'(avg_data), 6);
        check("not_full_yet", int'(window_full), 0);
        send(16); wait_avgs(1); check("fill_avg4", int'(avg_data), 10);
        check("full_after4", int'(window_full), 1);
        check("tick_count", n_avg - start, 4);
        send(20); wait_avgs(1); check("wrap_avg5", int'(avg_data), 14);
        send(0);  wait_avgs(1); check("wrap_avg6", int'(avg_data), 12);
        check("full_stays", int'(window_full), 1);

        // Clear then rounding
        pulse_clr();
        check("clr_avg_zero", int'(avg_data), 0);
        check("clr_not_full", int'(window_full), 0);
        check("clr_busy", int'(busy), 0);
        send(6); wait_avgs(1);
`ifdef AVG_ROUND_EN
        check("round_avg6", int'(avg_data), 2);
`else
        check("trunc_avg6", int'(avg_data), 1);
`endif
        for (int i = 0; i < 4; i++) begin
            send(255);
            wait_avgs(1);
        end
        check("max_avg", int'(avg_data), 255);

        // run dropped in READ: sample still completes, then idle
        send(9);
        run = 1'b0; in_valid = 1'b1;
        wait_avgs(1);
        check("drop_busy", int'(busy), 0);
        check("drop_in_ready", int'(in_ready), 0);
        start = n_avg;
        repeat (6) @(posedge clk);
        #1;
        check("drop_no_more", n_avg - start, 0);
        check("drop_still_idle", int'(in_ready), 0);
        in_valid = 1'b0; run = 1'b1;

        // clr during UPDATE discards the in-flight sample
        send(3);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("clrupd_busy", int'(busy), 0);
        check("clrupd_avg", int'(avg_data), 0);
        start = n_avg;
        repeat (5) @(posedge clk);
        #1;
        check("clrupd_no_avg", n_avg - start, 0);
        send(8); wait_avgs(1);
        check("after_clr_avg", int'(avg_data), 2);

        // Randomized traffic
        start = n_avg;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            run      = ($urandom_range(0, 9) != 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = DATA_W'($urandom);
            clr      = ($urandom_range(0, 59) == 0);
        end
        @(posedge clk);
        #1 clr = 1'b0; in_valid = 1'b0; run = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        check("random_avgs_seen", int'((n_avg - start) > 20), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
